inemo_spi_serf: RTL and testbench

- Synthesizable SPI responder (serf) that emulates the inertial sensor end of the SPI link driven by the inertial interface master.
- Decodes 16-bit command frames and serves a small register file, including WHO_AM_I, four config registers, and snapshot pitch/roll/yaw/ax/ay data.
- Raises INT when a new sample is latched.
- Replaces the behavioural sensor model for FPGA bring-up and for gate-level co-simulation.

---
 rtl/inemo_spi_serf.sv | 259 +++++++++++++++++++++++++
 tb/tb_inemo_spi_serf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inemo_spi_serf.sv
// SPI mode-3 responder emulating the inertial sensor: command decode, small register
// file, coherent sample snapshot and data-ready interrupt.
//   state | meaning
//   IDLE  | waiting for SS_n fall
//   CMD   | shifting R/W + address (rises 1..8)
//   DATA  | shifting data byte in/out (rises 9..16), extra rises ignored
module inemo_spi_serf #(
  parameter logic [7:0] WHO_AM_I = 8'h6A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        data_rdy,
  input  logic [15:0] ptch,
  input  logic [15:0] roll,
  input  logic [15:0] yaw,
  input  logic [15:0] ax,
  input  logic [15:0] ay,
  output logic        setup_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic ss_s1_q, ss_s2_q, ss_s3_q;
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  // SS_n sync resets low so a select already asserted at reset release is not seen
  // as a fresh fall; the partial frame is ignored until the next real fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1_q   <= 1'b0;
      ss_s2_q   <= 1'b0;
      ss_s3_q   <= 1'b0;
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_s3_q <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      ss_s1_q   <= SS_n;
      ss_s2_q   <= ss_s1_q;
      ss_s3_q   <= ss_s2_q;
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shft_q, shft_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        done_q, done_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  int1_ctrl_q, int1_ctrl_d;
  logic [7:0]  ctrl1_xl_q, ctrl1_xl_d;
  logic [7:0]  ctrl2_g_q, ctrl2_g_d;
  logic [7:0]  ctrl3_c_q, ctrl3_c_d;
  logic [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d, ax_q, ax_d, ay_q, ay_d;
  logic        pend_q, pend_d;
  logic        int_q, int_d;
  logic        setup_done_q, setup_done_d;

  logic [7:0] shift_byte;
  logic [7:0] rd_byte;
  logic       latch;
  logic       int_clr;

  assign shift_byte = {shft_q[6:0], mosi_s2_q};

  always_comb begin
    rd_byte = 8'h00;
    case (shift_byte[6:0])
      7'h0D: rd_byte = int1_ctrl_q;
      7'h0F: rd_byte = WHO_AM_I;
      7'h10: rd_byte = ctrl1_xl_q;
      7'h11: rd_byte = ctrl2_g_q;
      7'h14: rd_byte = ctrl3_c_q;
      7'h22: rd_byte = ptch_q[7:0];
      7'h23: rd_byte = ptch_q[15:8];
      7'h24: rd_byte = roll_q[7:0];
      7'h25: rd_byte = roll_q[15:8];
      7'h26: rd_byte = yaw_q[7:0];
      7'h27: rd_byte = yaw_q[15:8];
      7'h28: rd_byte = ax_q[7:0];
      7'h29: rd_byte = ax_q[15:8];
      7'h2A: rd_byte = ay_q[7:0];
      7'h2B: rd_byte = ay_q[15:8];
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shft_d    = shft_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    done_d    = done_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    int_clr   = 1'b0;
    if (ss_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      done_d  = 1'b0;
      int_clr = done_q & rw_q & (addr_q == 7'h27);
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (ss_fall) begin
            cnt_d   = 4'd0;
            done_d  = 1'b0;
            state_d = CMD;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shft_d = shift_byte;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d    = shift_byte[7];
              addr_d  = shift_byte[6:0];
              tx_d    = shift_byte[7] ? rd_byte : 8'h00;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise && !done_q) begin
            shft_d = shift_byte;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              done_d    = 1'b1;
              wr_en_d   = ~rw_q;
              wr_data_d = shift_byte;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    int1_ctrl_d  = int1_ctrl_q;
    ctrl1_xl_d   = ctrl1_xl_q;
    ctrl2_g_d    = ctrl2_g_q;
    ctrl3_c_d    = ctrl3_c_q;
    setup_done_d = setup_done_q;
    if (wr_en_q) begin
      case (addr_q)
        7'h0D: begin
          int1_ctrl_d = wr_data_q;
          if (wr_data_q[1]) setup_done_d = 1'b1;
        end
        7'h10: ctrl1_xl_d = wr_data_q;
        7'h11: ctrl2_g_d  = wr_data_q;
        7'h14: ctrl3_c_d  = wr_data_q;
        default: ;
      endcase
    end
  end

  // Samples arriving mid-transaction are deferred to SS_n rise so L/H reads stay coherent.
  always_comb begin
    latch  = (data_rdy & ss_s2_q) | (pend_q & ss_rise);
    pend_d = pend_q;
    if (data_rdy && !ss_s2_q) pend_d = 1'b1;
    else if (pend_q && ss_rise) pend_d = 1'b0;
    ptch_d = latch ? ptch : ptch_q;
    roll_d = latch ? roll : roll_q;
    yaw_d  = latch ? yaw  : yaw_q;
    ax_d   = latch ? ax   : ax_q;
    ay_d   = latch ? ay   : ay_q;
    int_d  = int_q;
    if (int_clr) int_d = 1'b0;
    if (latch && int1_ctrl_q[1]) int_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      shft_q       <= 8'h00;
      rw_q         <= 1'b0;
      addr_q       <= 7'h00;
      tx_q         <= 8'h00;
      miso_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 8'h00;
      int1_ctrl_q  <= 8'h00;
      ctrl1_xl_q   <= 8'h00;
      ctrl2_g_q    <= 8'h00;
      ctrl3_c_q    <= 8'h00;
      ptch_q       <= 16'h0000;
      roll_q       <= 16'h0000;
      yaw_q        <= 16'h0000;
      ax_q         <= 16'h0000;
      ay_q         <= 16'h0000;
      pend_q       <= 1'b0;
      int_q        <= 1'b0;
      setup_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shft_q       <= shft_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      done_q       <= done_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      int1_ctrl_q  <= int1_ctrl_d;
      ctrl1_xl_q   <= ctrl1_xl_d;
      ctrl2_g_q    <= ctrl2_g_d;
      ctrl3_c_q    <= ctrl3_c_d;
      ptch_q       <= ptch_d;
      roll_q       <= roll_d;
      yaw_q        <= yaw_d;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      pend_q       <= pend_d;
      int_q        <= int_d;
      setup_done_q <= setup_done_d;
    end
  end

  assign MISO       = miso_q;
  assign INT        = int_q;
  assign setup_done = setup_done_q;

endmodule

// File: tb/tb_inemo_spi_serf.sv
// Bench for inemo_spi_serf: directed scenarios then random frames checked against a
// register-level model of the sensor.
module tb_inemo_spi_serf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        INT;
  logic        data_rdy = 1'b0;
  logic [15:0] ptch = 16'h0, roll = 16'h0, yaw = 16'h0, ax = 16'h0, ay = 16'h0;
  logic        setup_done;

  int n_cmp = 0;
  int n_bad = 0;

  inemo_spi_serf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .INT(INT), .data_rdy(data_rdy), .ptch(ptch), .roll(roll), .yaw(yaw), .ax(ax),
    .ay(ay), .setup_done(setup_done)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  m_int1, m_xl, m_g, m_c;
  logic [15:0] m_sh[5];
  logic [15:0] nxt[5];
  logic        m_int, m_setup;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    logic [15:0] w;
    case (a)
      7'h0D: return m_int1;
      7'h0F: return 8'h6A;
      7'h10: return m_xl;
      7'h11: return m_g;
      7'h14: return m_c;
      default: begin
        if (a >= 7'h22 && a <= 7'h2B) begin
          w = m_sh[(int'(a) - 34) / 2];
          return a[0] ? w[15:8] : w[7:0];
        end
        return 8'h00;
      end
    endcase
  endfunction

  task automatic model_wr(input logic [6:0] a, input logic [7:0] d);
    case (a)
      7'h0D: begin m_int1 = d; if (d[1]) m_setup = 1'b1; end
      7'h10: m_xl = d;
      7'h11: m_g = d;
      7'h14: m_c = d;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_int1 = 0; m_xl = 0; m_g = 0; m_c = 0; m_int = 0; m_setup = 0;
    for (int i = 0; i < 5; i++) m_sh[i] = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic drive_vals();
    ptch = nxt[0]; roll = nxt[1]; yaw = nxt[2]; ax = nxt[3]; ay = nxt[4];
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 5; i++) nxt[i] = 16'($urandom);
  endtask

  task automatic ss_low();
    @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high();
    SS_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // one SCLK period at clk/8: fall, MOSI set, MISO sampled just before the rise
  task automatic send_bit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    repeat (4) @(negedge clk);
    m = MISO;
    SCLK = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rdy();
    @(negedge clk);
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
  endtask

  // sample presented while the link is idle
  task automatic idle_rdy();
    drive_vals();
    pulse_rdy();
    m_sh = nxt;
    if (m_int1[1]) m_int = 1'b1;
    chk("int_after_rdy", {15'h0, INT}, {15'h0, m_int});
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits, input bit mid, input string tag);
    logic [7:0] exp_rd, rd;
    logic       b, m, cm;
    logic [6:0] a;
    a = cmd[14:8];
    exp_rd = model_rd(a);
    rd = 8'h00;
    cm = 1'b0;
    ss_low();
    if (mid) begin
      drive_vals();
      pulse_rdy();
    end
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? cmd[15-i] : 1'($urandom);
      send_bit(b, m);
      if (i < 8) cm = cm | m;
      else if (i < 16) rd[15-i] = m;
    end
    ss_high();
    if (nbits >= 16) begin
      if (cmd[15]) begin
        chk({tag, "_rd"}, {8'h0, rd}, {8'h0, exp_rd});
        if (a == 7'h27) m_int = 1'b0;
      end else begin
        model_wr(a, cmd[7:0]);
      end
    end
    if (mid) begin
      m_sh = nxt;
      if (m_int1[1]) m_int = 1'b1;
    end
    chk({tag, "_int"}, {15'h0, INT}, {15'h0, m_int});
    chk({tag, "_setup"}, {15'h0, setup_done}, {15'h0, m_setup});
    chk({tag, "_cmd_miso"}, {15'h0, cm}, 16'h0);
    chk({tag, "_idle_miso"}, {15'h0, MISO}, 16'h0);
  endtask

  task automatic rd_chk(input logic [6:0] a, input string tag);
    frame({1'b1, a, 8'h00}, 16, 1'b0, tag);
  endtask

  logic [6:0] addrs[16] = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h22, 7'h23, 7'h24,
                            7'h25, 7'h26, 7'h27, 7'h28, 7'h29, 7'h2A, 7'h2B, 7'h7F};

  initial begin
    logic       m;
    logic [6:0] ra;
    int         op;
    model_reset();
    for (int i = 0; i < 5; i++) nxt[i] = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("rst_miso", {15'h0, MISO}, 16'h0);
    chk("rst_int", {15'h0, INT}, 16'h0);
    chk("rst_setup", {15'h0, setup_done}, 16'h0);

    frame(16'h8F00, 16, 1'b0, "whoami");

    frame(16'h0D02, 16, 1'b0, "wr_int1");
    nxt[0] = 16'h1234; nxt[1] = 16'h0; nxt[2] = 16'hBEEF; nxt[3] = 16'h0; nxt[4] = 16'h0;
    idle_rdy();
    frame(16'hA200, 16, 1'b0, "ptch_l");
    frame(16'hA300, 16, 1'b0, "ptch_h");
    frame(16'hA700, 16, 1'b0, "yaw_h_clr");

    nxt[2] = 16'h0001;
    frame(16'hA600, 16, 1'b1, "mid_rdy");
    rd_chk(7'h26, "yaw_l_new");

    do_reset();
    frame(16'h0D02, 10, 1'b0, "abort");
    rd_chk(7'h0D, "abort_int1");

    frame(16'h0F55, 16, 1'b0, "wr_ro");
    frame(16'h7FAA, 16, 1'b0, "wr_unmap");
    rd_chk(7'h0F, "whoami2");
    rd_chk(7'h7F, "unmapped");

    frame(16'h1155, 16, 1'b0, "pre_rst_wr");
    ss_low();
    for (int i = 0; i < 12; i++) send_bit(((16'h1011 >> (15 - i)) & 16'h1) != 0, m);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    ss_high();
    chk("midrst_miso", {15'h0, MISO}, 16'h0);
    rd_chk(7'h11, "midrst_g");
    frame(16'h1033, 16, 1'b0, "post_rst_wr");
    rd_chk(7'h10, "post_rst_rd");

    for (int k = 0; k < 90; k++) begin
      op = int'($urandom_range(0, 5));
      ra = addrs[$urandom_range(0, 15)];
      case (op)
        0: rd_chk(ra, "r_read");
        1: frame({1'b0, ra, 8'($urandom)}, 16, 1'b0, "r_write");
        2: begin rand_vals(); idle_rdy(); end
        3: begin rand_vals(); frame({1'b1, ra, 8'h00}, 16, 1'b1, "r_mid"); end
        4: frame(16'($urandom), int'($urandom_range(1, 15)), 1'b0, "r_abort");
        default: frame({1'($urandom), ra, 8'($urandom)}, int'($urandom_range(17, 20)), 1'b0, "r_long");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
